// File: rtl/beam_trigger_processor.sv
// Beam trigger processor: masks per-beam trigger pulses, issues hold-off limited trigger records
// over valid/ready, and keeps gated per-beam rate scalers readable through an addressed port.
module beam_trigger_processor #(
    parameter int NBEAMS    = 2,
    parameter int SCAL_BITS = 16,
    parameter int PERIOD    = 125000000,
    parameter int HOLDOFF   = 16,
    localparam int ADDR_BITS = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
    input  logic                 ifclk,
    input  logic                 rst_i,
    input  logic [NBEAMS-1:0]    trig_i,
    input  logic [NBEAMS-1:0]    mask_i,
    input  logic                 mask_wr_i,
    output logic                 trig_valid_o,
    input  logic                 trig_ready_i,
    output logic [NBEAMS-1:0]    trig_beams_o,
    input  logic [ADDR_BITS-1:0] scal_addr_i,
    output logic [SCAL_BITS-1:0] scal_dat_o,
    output logic                 scal_update_o,
    output logic [SCAL_BITS-1:0] dropped_o
);

    localparam int PCNT_BITS = $clog2(PERIOD);
    localparam int HCNT_BITS = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [SCAL_BITS-1:0] SCAL_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PEND,
        S_HOLD
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [NBEAMS-1:0]     r_mask;
    logic [NBEAMS-1:0]     r_beams;
    logic [NBEAMS-1:0]     w_eff;
    logic                  w_any;
    logic                  w_launch;
    logic                  w_accept;
    logic                  w_drop;
    logic [HCNT_BITS-1:0]  r_hold_cnt;
    logic [SCAL_BITS-1:0]  r_dropped;
    logic [PCNT_BITS-1:0]  r_pcnt;
    logic                  w_term;
    logic [SCAL_BITS-1:0]  r_run     [NBEAMS];
    logic [SCAL_BITS-1:0]  r_held    [NBEAMS];
    logic [SCAL_BITS-1:0]  w_run_inc [NBEAMS];
    logic [SCAL_BITS-1:0]  r_dat;
    logic                  r_update;

    assign w_eff  = trig_i & ~r_mask;
    assign w_any  = |w_eff;
    assign w_term = (r_pcnt == PCNT_BITS'(PERIOD - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ifclk) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_next_state = S_PEND;
            S_PEND:  if (trig_ready_i) w_next_state = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
            S_HOLD:  if (r_hold_cnt == HCNT_BITS'(1)) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        trig_valid_o = 1'b0;
        w_launch     = 1'b0;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            S_IDLE: w_launch = w_any;
            S_PEND: begin
                trig_valid_o = 1'b1;
                w_accept     = trig_ready_i;
                w_drop       = w_any;
            end
            default: ;
        endcase
    end

    // Triggers arriving while a record is pending are counted as lost, never merged into it.
    always_ff @(posedge ifclk) begin
        if (rst_i) begin
            r_mask     <= '1;
            r_beams    <= '0;
            r_hold_cnt <= '0;
            r_dropped  <= '0;
        end else begin
            if (mask_wr_i) r_mask <= mask_i;
            if (w_launch)  r_beams <= w_eff;
            if (w_accept)               r_hold_cnt <= HCNT_BITS'(HOLDOFF);
            else if (r_state == S_HOLD) r_hold_cnt <= r_hold_cnt - 1'b1;
            if (w_drop && (r_dropped != SCAL_MAX)) r_dropped <= r_dropped + 1'b1;
        end
    end

    always_comb begin
        for (int b = 0; b < NBEAMS; b++) begin
            w_run_inc[b] = (trig_i[b] && (r_run[b] != SCAL_MAX)) ? r_run[b] + 1'b1 : r_run[b];
        end
    end

    // NOTE: the scaler arrays are small register files that must read zero after reset, so they are reset explicitly.
    always_ff @(posedge ifclk) begin
        if (rst_i) begin
            r_pcnt   <= '0;
            r_update <= 1'b0;
            for (int b = 0; b < NBEAMS; b++) begin
                r_run[b]  <= '0;
                r_held[b] <= '0;
            end
        end else begin
            r_update <= w_term;
            r_pcnt   <= w_term ? '0 : r_pcnt + 1'b1;
            for (int b = 0; b < NBEAMS; b++) begin
                if (w_term) begin
                    r_held[b] <= w_run_inc[b];
                    r_run[b]  <= '0;
                end else begin
                    r_run[b]  <= w_run_inc[b];
                end
            end
        end
    end

    always_ff @(posedge ifclk) begin
        if (rst_i)                         r_dat <= '0;
        else if (int'(scal_addr_i) < NBEAMS) r_dat <= r_held[scal_addr_i];
        else                               r_dat <= '0;
    end

    assign trig_beams_o  = r_beams;
    assign scal_dat_o    = r_dat;
    assign scal_update_o = r_update;
    assign dropped_o     = r_dropped;

endmodule

// File: tb/tb_beam_trigger_processor.sv
// Directed bench for beam_trigger_processor: a cycle-level reference model checked every cycle,
// plus hand-computed expectations for reset, record timing, backpressure, gating and saturation.
module tb_beam_trigger_processor;

    localparam int NBEAMS    = 2;
    localparam int SCAL_BITS = 4;
    localparam int PERIOD    = 100;
    localparam int HOLDOFF   = 4;
    localparam int SMAX      = (1 << SCAL_BITS) - 1;

    logic                 ifclk = 1'b0;
    logic                 rst_i = 1'b1;
    logic [NBEAMS-1:0]    trig_i = '0;
    logic [NBEAMS-1:0]    mask_i = '0;
    logic                 mask_wr_i = 1'b0;
    logic                 trig_valid_o;
    logic                 trig_ready_i = 1'b0;
    logic [NBEAMS-1:0]    trig_beams_o;
    logic [0:0]           scal_addr_i = '0;
    logic [SCAL_BITS-1:0] scal_dat_o;
    logic                 scal_update_o;
    logic [SCAL_BITS-1:0] dropped_o;

    int total = 0;
    int bad   = 0;

    beam_trigger_processor #(
        .NBEAMS    (NBEAMS),
        .SCAL_BITS (SCAL_BITS),
        .PERIOD    (PERIOD),
        .HOLDOFF   (HOLDOFF)
    ) dut (
        .ifclk         (ifclk),
        .rst_i         (rst_i),
        .trig_i        (trig_i),
        .mask_i        (mask_i),
        .mask_wr_i     (mask_wr_i),
        .trig_valid_o  (trig_valid_o),
        .trig_ready_i  (trig_ready_i),
        .trig_beams_o  (trig_beams_o),
        .scal_addr_i   (scal_addr_i),
        .scal_dat_o    (scal_dat_o),
        .scal_update_o (scal_update_o),
        .dropped_o     (dropped_o)
    );

    always #5 ifclk = ~ifclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pending flag, a count of remaining dead cycles, and plain integer scalers
    // indexed by the number of clock edges since reset.
    bit         m_init = 1'b0;
    logic [1:0] m_mask;
    bit         m_pend;
    logic [1:0] m_beams;
    int         m_dead;
    int         m_drop;
    int         m_run  [NBEAMS];
    int         m_held [NBEAMS];
    int         m_cyc;
    bit         m_upd;
    int         m_dat;

    always @(posedge ifclk) begin
        logic [1:0] eff;
        int         v;
        bit         gate_end;
        if (rst_i) begin
            m_init  = 1'b1;
            m_mask  = 2'b11;
            m_pend  = 1'b0;
            m_beams = 2'b00;
            m_dead  = 0;
            m_drop  = 0;
            m_cyc   = 0;
            m_upd   = 1'b0;
            m_dat   = 0;
            for (int b = 0; b < NBEAMS; b++) begin
                m_run[b]  = 0;
                m_held[b] = 0;
            end
        end else begin
            eff = trig_i & ~m_mask;
            m_dat = (int'(scal_addr_i) < NBEAMS) ? m_held[scal_addr_i] : 0;
            if (m_pend) begin
                if (eff != 0) m_drop = (m_drop + 1 > SMAX) ? SMAX : m_drop + 1;
                if (trig_ready_i) begin
                    m_pend = 1'b0;
                    m_dead = HOLDOFF;
                end
            end else if (m_dead > 0) begin
                m_dead--;
            end else if (eff != 0) begin
                m_pend  = 1'b1;
                m_beams = eff;
            end
            if (mask_wr_i) m_mask = mask_i;
            gate_end = ((m_cyc % PERIOD) == PERIOD - 1);
            m_upd = gate_end;
            for (int b = 0; b < NBEAMS; b++) begin
                v = m_run[b] + int'(trig_i[b]);
                if (v > SMAX) v = SMAX;
                if (gate_end) begin
                    m_held[b] = v;
                    m_run[b]  = 0;
                end else begin
                    m_run[b]  = v;
                end
            end
            m_cyc++;
        end
    end

    always @(negedge ifclk) begin
        if (m_init) begin
            check("model_valid", trig_valid_o, m_pend);
            if (m_pend) check("model_beams", trig_beams_o, m_beams);
            check("model_dropped", dropped_o, m_drop);
            check("model_scal_dat", scal_dat_o, m_dat);
            check("model_scal_update", scal_update_o, m_upd);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge ifclk);
    endtask

    // Advance until the next clock edge is at position p within the scaler gate.
    task automatic goto_phase(input int p);
        for (int i = 0; i <= PERIOD && (m_cyc % PERIOD) != p; i++) @(negedge ifclk);
        if ((m_cyc % PERIOD) != p) begin
            total++;
            bad++;
            $display("FAIL goto_phase: phase %0d never reached", p);
        end
    endtask

    task automatic pulse_at(input int p, input logic [1:0] t);
        goto_phase(p);
        trig_i = t;
        tick(1);
        trig_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset, then a masked trigger: no record, but both scalers count it.
        tick(2);
        rst_i = 1'b0;
        trig_i = 2'b11;
        tick(1);
        trig_i = '0;
        check("t1_valid_masked", trig_valid_o, 1'b0);
        check("t1_beams_reset", trig_beams_o, 2'b00);
        tick(3);
        check("t1_valid_still_low", trig_valid_o, 1'b0);
        goto_phase(0);
        check("t1_update_pulse", scal_update_o, 1'b1);
        scal_addr_i = 1'b0;
        tick(1);
        check("t1_scal0", scal_dat_o, 4'd1);
        scal_addr_i = 1'b1;
        tick(1);
        check("t1_scal1", scal_dat_o, 4'd1);

        // Basic record with ready high, hold-off of four edges, then a new record.
        mask_i = 2'b00;
        mask_wr_i = 1'b1;
        tick(1);
        mask_wr_i = 1'b0;
        trig_ready_i = 1'b1;
        trig_i = 2'b10;
        tick(1);
        trig_i = '0;
        check("t2_valid_n1", trig_valid_o, 1'b1);
        check("t2_beams_n1", trig_beams_o, 2'b10);
        tick(1);
        check("t2_valid_n2", trig_valid_o, 1'b0);
        trig_i = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t2_holdoff_no_record", trig_valid_o, 1'b0);
        end
        tick(1);
        trig_i = '0;
        check("t2_valid_after_hold", trig_valid_o, 1'b1);
        check("t2_beams_after_hold", trig_beams_o, 2'b01);
        check("t2_dropped_zero", dropped_o, 4'd0);
        tick(1);
        check("t2_valid_cleared", trig_valid_o, 1'b0);
        tick(5);

        // Backpressure: record held, two lost trigger cycles, release on ready.
        trig_ready_i = 1'b0;
        trig_i = 2'b01;
        tick(1);
        trig_i = '0;
        check("t3_valid", trig_valid_o, 1'b1);
        check("t3_beams", trig_beams_o, 2'b01);
        tick(2);
        trig_i = 2'b11;
        tick(2);
        trig_i = '0;
        check("t3_dropped", dropped_o, 4'd2);
        check("t3_beams_unmerged", trig_beams_o, 2'b01);
        tick(3);
        check("t3_valid_held", trig_valid_o, 1'b1);
        trig_ready_i = 1'b1;
        tick(1);
        check("t3_valid_fall", trig_valid_o, 1'b0);
        tick(5);

        // Scaler gate: seven beam-0 pulses (one on the terminal edge) and three beam-1 pulses.
        goto_phase(0);
        for (int i = 0; i < 6; i++) pulse_at(10 + 2 * i, 2'b01);
        for (int i = 0; i < 3; i++) pulse_at(30 + i, 2'b10);
        pulse_at(PERIOD - 1, 2'b01);
        check("t4_update_pulse", scal_update_o, 1'b1);
        scal_addr_i = 1'b0;
        tick(1);
        check("t4_scal0", scal_dat_o, 4'd7);
        check("t4_update_one_cycle", scal_update_o, 1'b0);
        scal_addr_i = 1'b1;
        tick(1);
        check("t4_scal1", scal_dat_o, 4'd3);
        goto_phase(0);
        scal_addr_i = 1'b0;
        tick(1);
        check("t4_next_gate_scal0", scal_dat_o, 4'd0);
        scal_addr_i = 1'b1;
        tick(1);
        check("t4_next_gate_scal1", scal_dat_o, 4'd0);

        // Saturation: twenty back-to-back beam-0 pulses with the consumer stalled.
        trig_ready_i = 1'b0;
        trig_i = 2'b01;
        tick(20);
        trig_i = '0;
        check("t5_dropped_sat", dropped_o, 4'd15);
        goto_phase(0);
        scal_addr_i = 1'b0;
        tick(1);
        check("t5_scal0_sat", scal_dat_o, 4'd15);

        // Reset while a record is pending.
        check("t6_pending", trig_valid_o, 1'b1);
        rst_i = 1'b1;
        tick(1);
        check("t6_valid", trig_valid_o, 1'b0);
        check("t6_dropped", dropped_o, 4'd0);
        check("t6_scal_dat", scal_dat_o, 4'd0);
        check("t6_update", scal_update_o, 1'b0);
        rst_i = 1'b0;
        trig_ready_i = 1'b1;
        trig_i = 2'b11;
        tick(1);
        trig_i = '0;
        check("t6_mask_all_ones", trig_valid_o, 1'b0);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beam_trigger_processor.md
Name: beam_trigger_processor

Overview:
- Consumes the per-beam trigger bits delivered into ifclk by the beamformer trigger path (one ifclk-cycle pulse per event per beam).
- Applies a per-beam mask and issues a masked, hold-off-limited trigger record over a valid/ready handshake to the event/readout logic.
- Keeps per-beam rate scalers over a fixed gate period, readable through an addressed port.
- Single ifclk domain; all inputs synchronous to ifclk.

Parameters:
- NBEAMS, 2, number of beam trigger bits.
- SCAL_BITS, 16, scaler and drop-counter width (saturating).
- PERIOD, 125000000, scaler gate length in ifclk cycles (>=2).
- HOLDOFF, 16, dead cycles after an accepted trigger (0 allowed).
- localparam ADDR_BITS = max(1, clog2(NBEAMS)).

Ports:
- ifclk  in  1  clock.
- rst_i  in  1  reset.
- trig_i  in  NBEAMS  per-beam trigger; a bit high for one cycle = one event (back-to-back high cycles = separate events).
- mask_i  in  NBEAMS  new mask (1 = beam masked from trigger output).
- mask_wr_i  in  1  load mask_i.
- trig_valid_o  out  1  trigger record valid.
- trig_ready_i  in  1  consumer accepts record.
- trig_beams_o  out  NBEAMS  unmasked beams that formed the record.
- scal_addr_i  in  ADDR_BITS  scaler select.
- scal_dat_o  out  SCAL_BITS  held scaler for selected beam.
- scal_update_o  out  1  one-cycle pulse when held scalers refresh.
- dropped_o  out  SCAL_BITS  saturating count of cycles with lost triggers.

Behaviour:
- Reset: the clock and reset are already decided — one clock; reset is synchronous and active-high. Under rst_i, mask = all ones, trig_valid_o = 0, trig_beams_o = 0, FSM = IDLE, running and held scalers = 0, period counter = 0, scal_dat_o = 0, scal_update_o = 0, dropped_o = 0.
- Reset mid-operation: a pending record is discarded with no handshake completion, and all counters clear.
- Mask: mask_wr_i registers mask_i. The new mask applies from the next cycle's trig_i onward.
- Effective trigger: eff = trig_i & ~mask; any = |eff.
- FSM IDLE:
  - If any, the next cycle has trig_valid_o = 1 and trig_beams_o = eff; go to PEND.
- FSM PEND:
  - trig_valid_o and trig_beams_o hold stable until trig_ready_i is high.
  - On trig_valid_o & trig_ready_i: clear valid the next cycle, load the hold-off counter with HOLDOFF, and go to HOLD. If HOLDOFF = 0, go directly to IDLE.
  - Any cycle in PEND with any = 1, including the accept cycle, increments dropped_o (+1 per cycle, saturating at all ones). These triggers are not merged into the pending record.
- FSM HOLD:
  - The counter decrements each cycle; on reaching 1, go to IDLE. HOLD therefore lasts exactly HOLDOFF cycles.
  - Triggers in HOLD are ignored and are not counted as dropped.
  - The first cycle in IDLE may launch a new record.
- Trigger latency: trig_i high at cycle N in IDLE gives trig_valid_o high at cycle N+1.
- Scalers:
  - Each beam's running counter increments on trig_i[b], regardless of mask and FSM state, and saturates at 2^SCAL_BITS-1.
  - The period counter runs 0..PERIOD-1 continuously from reset.
  - On the terminal cycle, each held scaler ← running + trig_i[b] (saturating). Running counters ← 0, and scal_update_o pulses on the following cycle, coincident with the new held values.
- Readout: scal_dat_o is registered with one-cycle latency from scal_addr_i. Addresses ≥ NBEAMS return 0.

Test Plan:
- Mask after reset: reset, then trig_i=2'b11 for 1 cycle → trig_valid_o stays 0; scalers after the gate both = 1 (PERIOD=100, HOLDOFF=4 for all tests).
- Basic record: mask_wr_i with mask_i=2'b00; trig_i=2'b10 at cycle N, trig_ready_i=1 → valid high only at N+1, trig_beams_o=2'b10. A trigger at N+2..N+5 gives no record and dropped_o stays 0. A trigger at N+6 gives valid at N+7.
- Backpressure: trig_ready_i=0; trig_i=2'b01 at N, then 2'b11 at N+3 and N+4 → valid held with beams=2'b01, dropped_o=2. Assert ready at N+8 → valid falls at N+9.
- Scaler gate: 7 pulses on beam 0, one of them on the terminal cycle, plus 3 pulses on beam 1 → scal_update_o pulse. addr 0 reads 7 and addr 1 reads 3 one cycle after the address is applied; the next period starts from 0.
- Saturation: SCAL_BITS=4, 20 beam-0 pulses in one gate → held = 15. Dropped-counter saturation at 15 is checked the same way.
- Mid-operation reset: rst_i pulsed while in PEND → next cycle valid = 0, dropped_o = 0, scal_dat_o = 0, mask = 2'b11.
